// File: rtl/operand_bypass_unit_pkg.sv
// Shared pipeline types for the RV core hazard/forwarding logic.
// Scoreboard entry layout and post-decode stage index names.
package rv_pipe_pkg;

  // Widest register address any core variant uses; narrower AW is zero-extended.
  localparam int RD_W = 8;

  // Post-decode stage indices, youngest first.
  localparam int STG_E = 0;
  localparam int STG_M = 1;
  localparam int STG_W = 2;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            is_load;
    logic [RD_W-1:0] rd;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

endpackage

// File: rtl/operand_bypass_unit_if.sv
// Bus between the datapath and operand_bypass_unit.
// Optional HAZARD_PERF_EN adds the stall/flush performance counters.
interface operand_bypass_unit_if #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int STAGES = 3
);

  logic                   ext_stall;
  logic                   redirect;
  logic                   dec_valid;
  logic [AW-1:0]          dec_rs1;
  logic [AW-1:0]          dec_rs2;
  logic [AW-1:0]          dec_rd;
  logic                   dec_regwrite;
  logic                   dec_is_load;
  logic [XLEN-1:0]        rf_rd1;
  logic [XLEN-1:0]        rf_rd2;
  logic [STAGES*XLEN-1:0] stage_result;
  logic [XLEN-1:0]        fwd_rs1;
  logic [XLEN-1:0]        fwd_rs2;
  logic                   stall_d;
  logic                   flush_d;
  logic                   bubble_e;
`ifdef HAZARD_PERF_EN
  logic [31:0]            perf_stall_cnt;
  logic [31:0]            perf_flush_cnt;
`endif

  // Pipeline/datapath side.
  modport master (
    output ext_stall, redirect, dec_valid, dec_rs1, dec_rs2, dec_rd,
    output dec_regwrite, dec_is_load, rf_rd1, rf_rd2, stage_result,
    input  fwd_rs1, fwd_rs2, stall_d, flush_d, bubble_e
`ifdef HAZARD_PERF_EN
    , input perf_stall_cnt, perf_flush_cnt
`endif
  );

  // Hazard unit side.
  modport slave (
    input  ext_stall, redirect, dec_valid, dec_rs1, dec_rs2, dec_rd,
    input  dec_regwrite, dec_is_load, rf_rd1, rf_rd2, stage_result,
    output fwd_rs1, fwd_rs2, stall_d, flush_d, bubble_e
`ifdef HAZARD_PERF_EN
    , output perf_stall_cnt, perf_flush_cnt
`endif
  );

endinterface

// File: rtl/operand_bypass_unit_sb_stage_reg.sv
// One scoreboard entry: async clear, hold while disabled, bubble insert.
module sb_stage_reg
  import rv_pipe_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      en,
  input  logic      bubble,
  input  sb_entry_t din,
  output sb_entry_t dout
);

  // Advance the entry on enabled edges; a bubble loads an empty slot.
  // NOTE: state registers use <= so every stage samples its neighbour's old value on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout <= SB_EMPTY;
    end else if (en) begin
      dout <= bubble ? SB_EMPTY : din;
    end
  end

endmodule

// File: rtl/operand_bypass_unit.sv
// Operand bypass / hazard unit for the pipelined RV core.
// Tracks destination registers of in-flight instructions, forwards the
// youngest matching stage result to Decode, and raises load-use stall and
// redirect flush. Define HAZARD_PERF_EN to add stall/flush event counters.
module operand_bypass_unit
  import rv_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int AW         = 5,   // must not exceed RD_W
  parameter int STAGES     = 3,
  parameter int LOAD_STAGE = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  operand_bypass_unit_if.slave  bus
);

  sb_entry_t entry [STAGES];
  sb_entry_t decEntry;
  logic      stageEn;
  logic      bubbleE;
  logic      stallD;
  logic      unres1;
  logic      unres2;
  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;

  function automatic logic hits(sb_entry_t e, logic [AW-1:0] rs);
    return e.valid && e.regwrite && (e.rd == RD_W'(rs)) && (rs != '0);
  endfunction

  assign stageEn  = ~bus.ext_stall;
  assign decEntry = '{valid:    bus.dec_valid,
                      regwrite: bus.dec_regwrite,
                      is_load:  bus.dec_is_load,
                      rd:       RD_W'(bus.dec_rd)};

  // Scoreboard shift register: stage 0 takes Decode, stage k takes stage k-1.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      sb_stage_reg u_stage (
        .clk    (clk),
        .reset  (reset),
        .en     (stageEn),
        .bubble (bubbleE),
        .din    (decEntry),
        .dout   (entry[k])
      );
    end else begin : g_tail
      sb_stage_reg u_stage (
        .clk    (clk),
        .reset  (reset),
        .en     (stageEn),
        .bubble (1'b0),
        .din    (entry[k-1]),
        .dout   (entry[k])
      );
    end
  end

  // Pick the youngest matching stage per operand; scanning oldest-first lets
  // younger matches overwrite older ones.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fwd1   = bus.rf_rd1;
    fwd2   = bus.rf_rd2;
    unres1 = 1'b0;
    unres2 = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (hits(entry[k], bus.dec_rs1)) begin
        fwd1   = bus.stage_result[k*XLEN +: XLEN];
        unres1 = entry[k].is_load && (k < LOAD_STAGE);
      end
      if (hits(entry[k], bus.dec_rs2)) begin
        fwd2   = bus.stage_result[k*XLEN +: XLEN];
        unres2 = entry[k].is_load && (k < LOAD_STAGE);
      end
    end
  end

  // A redirect squashes the Decode instruction, so it never stalls.
  assign stallD  = bus.dec_valid & ~bus.redirect & (unres1 | unres2);
  assign bubbleE = bus.redirect | stallD;

  assign bus.fwd_rs1  = fwd1;
  assign bus.fwd_rs2  = fwd2;
  assign bus.stall_d  = stallD;
  assign bus.flush_d  = bus.redirect;
  assign bus.bubble_e = bubbleE;

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;

  // Count stall/flush events on edges where the pipeline actually advances.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else if (stageEn) begin
      if (stallD)       stallCnt <= stallCnt + 32'd1;
      if (bus.redirect) flushCnt <= flushCnt + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = stallCnt;
  assign bus.perf_flush_cnt = flushCnt;
`endif

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Directed self-checking bench for operand_bypass_unit (E/M/W, LOAD_STAGE=2).
// Perf-counter checks are included when HAZARD_PERF_EN is defined.
module tb_operand_bypass_unit;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int STG  = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  operand_bypass_unit_if #(.XLEN(XLEN), .AW(AW), .STAGES(STG)) bus ();

  operand_bypass_unit #(.XLEN(XLEN), .AW(AW), .STAGES(STG), .LOAD_STAGE(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Advance one edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setRes(input logic [XLEN-1:0] e, input logic [XLEN-1:0] m, input logic [XLEN-1:0] w);
    bus.stage_result = {w, m, e};
  endtask

  task automatic issue(input logic [AW-1:0] rd, input logic rw, input logic ld,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    bus.dec_valid    = 1'b1;
    bus.dec_rd       = rd;
    bus.dec_regwrite = rw;
    bus.dec_is_load  = ld;
    bus.dec_rs1      = rs1;
    bus.dec_rs2      = rs2;
  endtask

  task automatic idle();
    bus.dec_valid    = 1'b0;
    bus.dec_rd       = '0;
    bus.dec_regwrite = 1'b0;
    bus.dec_is_load  = 1'b0;
    bus.dec_rs1      = '0;
    bus.dec_rs2      = '0;
    bus.redirect     = 1'b0;
    bus.ext_stall    = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic expect1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    issue(5'd9, 1'b1, 1'b0, 5'd5, 5'd6);
    bus.rf_rd1 = 32'h1234_5678;
    bus.rf_rd2 = 32'h0000_9ABC;
    setRes(32'h11, 32'h22, 32'h33);
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (bus.fwd_rs1 !== 32'h1234_5678) begin failures++; $display("FAIL reset_fwd1 got=%h exp=%h", bus.fwd_rs1, 32'h1234_5678); end
    checks++;
    if (bus.fwd_rs2 !== 32'h0000_9ABC) begin failures++; $display("FAIL reset_fwd2 got=%h exp=%h", bus.fwd_rs2, 32'h0000_9ABC); end
    expect1("reset_stall", bus.stall_d, 1'b0);
    expect1("reset_flush", bus.flush_d, 1'b0);
    expect1("reset_bubble", bus.bubble_e, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    drain();
  endtask

  task automatic test_alu_chain();
    issue(5'd5, 1'b1, 1'b0, 5'd0, 5'd0);
    tick();
    issue(5'd9, 1'b0, 1'b0, 5'd5, 5'd0);
    setRes(32'h11, 32'h22, 32'h33);
    bus.rf_rd1 = 32'h99;
    #1;
    checks++;
    if (bus.fwd_rs1 !== 32'h11) begin failures++; $display("FAIL alu_fwd1 got=%h exp=%h", bus.fwd_rs1, 32'h11); end
    expect1("alu_stall", bus.stall_d, 1'b0);
    drain();
  endtask

  task automatic test_load_use();
    issue(5'd6, 1'b1, 1'b1, 5'd0, 5'd0);
    tick();
    issue(5'd9, 1'b1, 1'b0, 5'd0, 5'd6);
    setRes(32'h1, 32'h2, 32'hCAFE);
    bus.rf_rd2 = 32'h5;
    #1;
    expect1("lu_stall_c1", bus.stall_d, 1'b1);
    expect1("lu_bubble_c1", bus.bubble_e, 1'b1);
    tick();
    expect1("lu_stall_c2", bus.stall_d, 1'b1);
    expect1("lu_bubble_c2", bus.bubble_e, 1'b1);
    tick();
    expect1("lu_stall_c3", bus.stall_d, 1'b0);
    expect1("lu_bubble_c3", bus.bubble_e, 1'b0);
    checks++;
    if (bus.fwd_rs2 !== 32'hCAFE) begin failures++; $display("FAIL lu_fwd2 got=%h exp=%h", bus.fwd_rs2, 32'hCAFE); end
    drain();
  endtask

  task automatic test_load_in_m();
    issue(5'd12, 1'b1, 1'b1, 5'd0, 5'd0);
    tick();
    issue(5'd13, 1'b1, 1'b0, 5'd0, 5'd0);
    tick();
    issue(5'd14, 1'b1, 1'b0, 5'd12, 5'd0);
    setRes(32'h1, 32'h2, 32'hBEEF);
    #1;
    expect1("ldm_stall_c1", bus.stall_d, 1'b1);
    tick();
    expect1("ldm_stall_c2", bus.stall_d, 1'b0);
    checks++;
    if (bus.fwd_rs1 !== 32'hBEEF) begin failures++; $display("FAIL ldm_fwd1 got=%h exp=%h", bus.fwd_rs1, 32'hBEEF); end
    drain();
  endtask

  task automatic test_youngest();
    issue(5'd7, 1'b1, 1'b0, 5'd0, 5'd0);
    tick();
    issue(5'd8, 1'b1, 1'b0, 5'd0, 5'd0);
    tick();
    issue(5'd7, 1'b1, 1'b0, 5'd0, 5'd0);
    tick();
    issue(5'd15, 1'b0, 1'b0, 5'd7, 5'd8);
    setRes(32'hA, 32'hC, 32'hB);
    #1;
    checks++;
    if (bus.fwd_rs1 !== 32'hA) begin failures++; $display("FAIL young_fwd1 got=%h exp=%h", bus.fwd_rs1, 32'hA); end
    checks++;
    if (bus.fwd_rs2 !== 32'hC) begin failures++; $display("FAIL young_fwd2 got=%h exp=%h", bus.fwd_rs2, 32'hC); end
    expect1("young_stall", bus.stall_d, 1'b0);
    tick();
    // x7 now in M, x8 in W.
    checks++;
    if (bus.fwd_rs1 !== 32'hC) begin failures++; $display("FAIL young_m_fwd1 got=%h exp=%h", bus.fwd_rs1, 32'hC); end
    checks++;
    if (bus.fwd_rs2 !== 32'hB) begin failures++; $display("FAIL young_w_fwd2 got=%h exp=%h", bus.fwd_rs2, 32'hB); end
    drain();
  endtask

  task automatic test_x0();
    issue(5'd0, 1'b1, 1'b0, 5'd0, 5'd0);
    tick();
    issue(5'd0, 1'b1, 1'b1, 5'd0, 5'd0);
    tick();
    issue(5'd9, 1'b0, 1'b0, 5'd0, 5'd0);
    setRes(32'h55, 32'h66, 32'h0);
    bus.rf_rd1 = 32'h0;
    bus.rf_rd2 = 32'h0;
    #1;
    checks++;
    if (bus.fwd_rs1 !== 32'h0) begin failures++; $display("FAIL x0_fwd1 got=%h exp=%h", bus.fwd_rs1, 32'h0); end
    checks++;
    if (bus.fwd_rs2 !== 32'h0) begin failures++; $display("FAIL x0_fwd2 got=%h exp=%h", bus.fwd_rs2, 32'h0); end
    expect1("x0_stall", bus.stall_d, 1'b0);
    drain();
  endtask

  task automatic test_redirect();
    issue(5'd6, 1'b1, 1'b1, 5'd0, 5'd0);
    tick();
    issue(5'd10, 1'b1, 1'b0, 5'd6, 5'd0);
    bus.redirect = 1'b1;
    #1;
    expect1("redir_stall", bus.stall_d, 1'b0);
    expect1("redir_flush", bus.flush_d, 1'b1);
    expect1("redir_bubble", bus.bubble_e, 1'b1);
    tick();
    bus.redirect = 1'b0;
    issue(5'd11, 1'b0, 1'b0, 5'd10, 5'd6);
    setRes(32'h77, 32'h88, 32'h99);
    bus.rf_rd1 = 32'h33;
    #1;
    checks++;
    if (bus.fwd_rs1 !== 32'h33) begin failures++; $display("FAIL redir_e_invalid got=%h exp=%h", bus.fwd_rs1, 32'h33); end
    expect1("redir_load_in_m_stall", bus.stall_d, 1'b1);
    expect1("redir_flush_clear", bus.flush_d, 1'b0);
    drain();
  endtask

  task automatic test_ext_stall();
    issue(5'd6, 1'b1, 1'b1, 5'd0, 5'd0);
    tick();
    issue(5'd11, 1'b1, 1'b0, 5'd6, 5'd0);
    bus.ext_stall = 1'b1;
    setRes(32'hE0, 32'hE1, 32'hE2);
    bus.rf_rd1 = 32'h4444;
    for (int i = 0; i < 3; i++) begin
      #1;
      expect1($sformatf("xs_stall_c%0d", i), bus.stall_d, 1'b1);
      tick();
    end
    // Asynchronous reset in the middle of a frozen cycle.
    #2;
    reset = 1'b0;
    #1;
    expect1("xs_rst_stall", bus.stall_d, 1'b0);
    checks++;
    if (bus.fwd_rs1 !== 32'h4444) begin failures++; $display("FAIL xs_rst_fwd1 got=%h exp=%h", bus.fwd_rs1, 32'h4444); end
`ifdef HAZARD_PERF_EN
    checks++;
    if (bus.perf_stall_cnt !== 32'd0) begin failures++; $display("FAIL xs_rst_perf_stall got=%0d exp=0", bus.perf_stall_cnt); end
    checks++;
    if (bus.perf_flush_cnt !== 32'd0) begin failures++; $display("FAIL xs_rst_perf_flush got=%0d exp=0", bus.perf_flush_cnt); end
`endif
    #1;
    reset = 1'b1;
    bus.ext_stall = 1'b0;
    tick();
    expect1("xs_post_rst_stall", bus.stall_d, 1'b0);
    drain();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    issue(5'd6, 1'b1, 1'b1, 5'd0, 5'd0);
    tick();
    issue(5'd9, 1'b1, 1'b0, 5'd6, 5'd0);
    repeat (3) tick();
    idle();
    bus.redirect = 1'b1;
    tick();
    bus.ext_stall = 1'b1;
    tick();
    idle();
    tick();
    checks++;
    if (bus.perf_stall_cnt !== 32'd2) begin failures++; $display("FAIL perf_stall got=%0d exp=2", bus.perf_stall_cnt); end
    checks++;
    if (bus.perf_flush_cnt !== 32'd1) begin failures++; $display("FAIL perf_flush got=%0d exp=1", bus.perf_flush_cnt); end
  endtask
`endif

  initial begin
    bus.rf_rd1       = '0;
    bus.rf_rd2       = '0;
    bus.stage_result = '0;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_load_in_m();
    test_youngest();
    test_x0();
    test_redirect();
    test_ext_stall();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_bypass_unit.md
Name: operand_bypass_unit

Overview:
- Parametrised hazard and forwarding block for the pipelined RV core.
- Keeps a scoreboard of the destination registers of in-flight instructions across the post-decode stages (E, M, W by default).
- Resolves the Decode-stage rs1/rs2 operands from the youngest matching stage result, or from the register file when nothing matches.
- Raises a load-use stall and a redirect flush. Replaces ad-hoc stall/flush wiring around the datapath pipeline registers.

Parameters:
XLEN, 32, operand/result data width
AW, 5, register address width (2**AW architectural registers, x0 hardwired zero)
STAGES, 3, number of tracked post-decode stages (index 0 = E, youngest)
LOAD_STAGE, 2, first stage index at which load data is valid in stage_result (1..STAGES-1)

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset
ext_stall  in  1  global freeze (memory wait); scoreboard holds
redirect  in  1  taken branch/jump resolved in E this cycle
dec_valid  in  1  Decode holds a valid instruction
dec_rs1  in  AW  Decode source 1
dec_rs2  in  AW  Decode source 2
dec_rd  in  AW  Decode destination
dec_regwrite  in  1  Decode instruction writes rd
dec_is_load  in  1  Decode instruction is a load
rf_rd1  in  XLEN  register file read data 1
rf_rd2  in  XLEN  register file read data 2
stage_result  in  STAGES*XLEN  result of stage k at bits [k*XLEN +: XLEN]
fwd_rs1  out  XLEN  resolved operand 1
fwd_rs2  out  XLEN  resolved operand 2
stall_d  out  1  hold PC and F/D register (load-use)
flush_d  out  1  clear F/D register
bubble_e  out  1  a bubble enters E next edge

Behaviour:
- Scoreboard entry per stage: {valid, regwrite, is_load, rd}. Reset (asynchronous, reset=0) clears every valid bit. Reset mid-operation discards all entries immediately.
- Reset values: stall_d=0, flush_d=0, bubble_e=0. fwd_rs* follow rf_rd* because no entries are valid.
- Match(k, rs): valid[k] & regwrite[k] & rd[k]==rs & rs!=0.
- Forwarding (combinational):
  - Select the lowest k that matches.
  - If that entry is a load with k<LOAD_STAGE, the operand is unresolved and fwd_rs* is don't-care.
  - Otherwise fwd_rs* = stage_result[k].
  - If no k matches, fwd_rs* = rf_rd*.
  - rs=0 always yields rf_rd* (expected 0).
- stall_d = dec_valid & ~redirect & (rs1 unresolved | rs2 unresolved). This is zero-cycle combinational.
- flush_d = redirect.
- bubble_e = redirect | stall_d.
- Update on each rising edge when ext_stall=0:
  - entry[k] <= entry[k-1] for k>=1.
  - entry[0] <= bubble_e ? invalid : {dec_valid, dec_regwrite, dec_is_load, dec_rd}.
  - The entry leaving stage STAGES-1 is dropped.
- ext_stall=1: all entries hold, and stall_d/flush_d are still computed from current state. The external controller ORs in its own freeze.
- redirect together with a load-use hazard: redirect wins, stall_d=0, flush_d=1, one bubble.
- A load with k>=LOAD_STAGE forwards normally. Back-to-back dependent loads stall exactly LOAD_STAGE-k cycles.
- Same register written by several in-flight instructions: the youngest wins.
- W-stage write and D read of the same register in one cycle: forwarding from W covers it, independent of regfile write timing.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0]. Each increments by 1 on every non-ext_stall edge where stall_d (resp. flush_d) is 1. Both are cleared by reset and wrap at 2**32.
- Undefined: ports and counters are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package rv_pipe_pkg:
  - sb_entry_t {valid, regwrite, is_load, rd[AW-1:0]}.
  - Stage index constants STG_E=0, STG_M=1, STG_W=2.
- One sub-module sb_stage_reg: a single scoreboard entry with async active-low clear, enable (~ext_stall), and bubble insert. Instantiated STAGES times in a generate loop.
- Forward-select priority logic stays in the top module.

Test Plan:
- ALU chain: I0 "x5=ALU" in E with stage_result[E]=0x11, D reads rs1=x5 -> fwd_rs1=0x11, stall_d=0.
- Load-use: load rd=x6 in E, D reads rs2=x6 -> stall_d=1 and bubble_e=1 for exactly 2 cycles. On the third cycle the load is in W, fwd_rs2=stage_result[W]=0xCAFE, stall_d=0.
- Youngest wins: x7 in E (0xA) and x7 in W (0xB), rs1=x7 -> fwd_rs1=0xA.
- x0: entry rd=0 in E with value 0x55, rs1=0, rf_rd1=0 -> fwd_rs1=0 and no stall.
- Redirect during load-use hazard: redirect=1 -> stall_d=0, flush_d=1. The next cycle entry[E] is invalid.
- ext_stall held 3 cycles with load in E, then async reset pulse mid-stall -> scoreboard frozen during ext_stall. After reset all entries are invalid and stall_d=0. With HAZARD_PERF_EN both counters read 0.
